ps2_command_decoder: RTL and testbench

Receives PS/2 keyboard frames and turns key presses into the 3-bit `keyboard_signal` command bus consumed by the game controller. Each command is a single-cycle pulse; the bus is 000 at all other times. The block sits between the board's PS/2 pins and the game control block. It provides:
- pin synchronisation
- frame reception with parity, stop-bit and timeout checking
- E0/F0 prefix handling
- key-to-command mapping

---
 rtl/ps2_pkg.sv | 59 +++++
 rtl/ps2_frame_rx.sv | 117 +++++++++++
 rtl/ps2_command_decoder.sv | 92 +++++++++
 tb/tb_ps2_command_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard path: command codes, scan codes,
// frame geometry, receiver states and the key-to-command lookup.
package ps2_pkg;

    localparam logic [2:0] CMD_IDLE   = 3'b000;
    localparam logic [2:0] CMD_DOWN   = 3'b100;
    localparam logic [2:0] CMD_LEFT   = 3'b101;
    localparam logic [2:0] CMD_RIGHT  = 3'b110;
    localparam logic [2:0] CMD_ROTATE = 3'b111;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
    localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
    localparam logic [7:0] SC_ARROW_UP    = 8'h75;

    localparam logic [7:0] SC_KEY_S = 8'h1B;
    localparam logic [7:0] SC_KEY_A = 8'h1C;
    localparam logic [7:0] SC_KEY_D = 8'h23;
    localparam logic [7:0] SC_KEY_W = 8'h1D;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = FRAME_BITS - 3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    function automatic logic [2:0] map_key(input logic [7:0] code,
                                           input logic       extended);
        logic [2:0] cmd;
        cmd = CMD_IDLE;
        if (extended) begin
            case (code)
                SC_ARROW_DOWN:  cmd = CMD_DOWN;
                SC_ARROW_LEFT:  cmd = CMD_LEFT;
                SC_ARROW_RIGHT: cmd = CMD_RIGHT;
                SC_ARROW_UP:    cmd = CMD_ROTATE;
                default:        cmd = CMD_IDLE;
            endcase
        end else begin
            case (code)
                SC_KEY_S: cmd = CMD_DOWN;
                SC_KEY_A: cmd = CMD_LEFT;
                SC_KEY_D: cmd = CMD_RIGHT;
                SC_KEY_W: cmd = CMD_ROTATE;
                default:  cmd = CMD_IDLE;
            endcase
        end
        return cmd;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, bit FSM,
// odd-parity/stop checking and inter-edge timeout. Result outputs are
// combinational pulses aligned with the detected stop-bit edge.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       clk_sync_q,  clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;
    logic             clk_prev_q,  clk_prev_d;
    rx_state_e        state_q,     state_d;
    logic [2:0]       bit_cnt_q,   bit_cnt_d;
    logic [7:0]       shift_q,     shift_d;
    logic             parity_q,    parity_d;
    logic [CNT_W-1:0] timeout_q,   timeout_d;

    logic fall;
    logic bit_in;

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        clk_prev_d  = clk_sync_q[1];
        fall        = clk_prev_q & ~clk_sync_q[1];
        bit_in      = data_sync_q[1];
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        timeout_d   = timeout_q;
        byte_valid  = 1'b0;
        frame_error = 1'b0;
        rx_byte     = shift_q;

        if (fall) begin
            // A detected edge always resets the watchdog, even on its last cycle.
            timeout_d = '0;
            case (state_q)
                RX_IDLE: begin
                    if (!bit_in) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = '0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        state_d = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    parity_d = bit_in;
                    state_d  = RX_STOP;
                end
                RX_STOP: begin
                    state_d = RX_IDLE;
                    if (bit_in && (^{shift_q, parity_q})) begin
                        byte_valid = 1'b1;
                    end else begin
                        frame_error = 1'b1;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (state_q != RX_IDLE) begin
            if (timeout_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                frame_error = 1'b1;
                state_d     = RX_IDLE;
                timeout_d   = '0;
            end else begin
                timeout_d = timeout_q + 1'b1;
            end
        end else begin
            timeout_d = '0;
        end
    end

    // Synchronisers reset to the idle-high line level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            state_q     <= RX_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            timeout_q   <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            timeout_q   <= timeout_d;
        end
    end

endmodule

// File: rtl/ps2_command_decoder.sv
// Turns received PS/2 bytes into one-cycle game commands, tracking the
// E0 (extended) and F0 (break) prefixes between bytes.
module ps2_command_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [2:0] keyboard_signal,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_error;

    logic       ext_pending_q, ext_pending_d;
    logic       brk_pending_q, brk_pending_d;
    logic [2:0] cmd_q,         cmd_d;
    logic [7:0] scan_code_q,   scan_code_d;
    logic       scan_valid_q,  scan_valid_d;
    logic       frame_error_q, frame_error_d;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .frame_error(rx_error)
    );

    always_comb begin
        ext_pending_d = ext_pending_q;
        brk_pending_d = brk_pending_q;
        cmd_d         = CMD_IDLE;
        scan_code_d   = scan_code_q;
        scan_valid_d  = rx_valid;
        frame_error_d = rx_error;

        if (rx_valid) begin
            scan_code_d = rx_byte;
            if (rx_byte == SC_EXT) begin
                ext_pending_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_pending_d = 1'b1;
            end else begin
                // Releases are swallowed; only makes (including typematic repeats) fire.
                if (!brk_pending_q) begin
                    cmd_d = map_key(rx_byte, ext_pending_q);
                end
                ext_pending_d = 1'b0;
                brk_pending_d = 1'b0;
            end
        end else if (rx_error) begin
            ext_pending_d = 1'b0;
            brk_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_pending_q <= 1'b0;
            brk_pending_q <= 1'b0;
            cmd_q         <= CMD_IDLE;
            scan_code_q   <= 8'h00;
            scan_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            ext_pending_q <= ext_pending_d;
            brk_pending_q <= brk_pending_d;
            cmd_q         <= cmd_d;
            scan_code_q   <= scan_code_d;
            scan_valid_q  <= scan_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign keyboard_signal = cmd_q;
    assign scan_code       = scan_code_q;
    assign scan_valid      = scan_valid_q;
    assign frame_error     = frame_error_q;

endmodule

// File: tb/tb_ps2_command_decoder.sv
// Self-checking bench for ps2_command_decoder: directed PS/2 frames, a
// frame-level reference model with per-cycle comparison, and literal checks.
module tb_ps2_command_decoder;

    localparam int TIMEOUT = 300;
    localparam int HALF    = 8;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [2:0] keyboard_signal;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_error;

    int   cyc        = 0;
    logic rstSampled = 1'b1;

    typedef struct {
        int         at;
        logic       sv;
        logic       fe;
        logic [7:0] code;
        logic [2:0] cmd;
    } exp_t;

    exp_t       expQ[$];
    logic [2:0] wasdMap  [logic [7:0]];
    logic [2:0] arrowMap [logic [7:0]];
    logic       mExt  = 1'b0;
    logic       mBrk  = 1'b0;
    logic [7:0] mCode = 8'h00;

    int         compared   = 0;
    int         mismatched = 0;
    int         svPulses   = 0;
    int         cmdPulses  = 0;
    int         errPulses  = 0;
    logic [2:0] lastCmd    = 3'b000;
    logic       errWindow  = 1'b0;

    ps2_command_decoder #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .keyboard_signal(keyboard_signal),
        .scan_code      (scan_code),
        .scan_valid     (scan_valid),
        .frame_error    (frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        rstSampled <= rst;
    end

    // Reference: a complete frame is judged as a whole and its effect lands
    // three clock edges after the stop-bit fall reaches the pin.
    task automatic modelFrame(input logic [7:0] b, input logic p, input logic stopBit, input int at);
        exp_t e;
        e.at = at; e.sv = 1'b0; e.fe = 1'b0; e.code = 8'h00; e.cmd = 3'b000;
        if (!stopBit || ($countones({b, p}) % 2) != 1) begin
            e.fe = 1'b1;
            mExt = 1'b0;
            mBrk = 1'b0;
        end else begin
            e.sv   = 1'b1;
            e.code = b;
            if (b == 8'hE0) mExt = 1'b1;
            else if (b == 8'hF0) mBrk = 1'b1;
            else begin
                if (!mBrk) begin
                    if (mExt) begin
                        if (arrowMap.exists(b)) e.cmd = arrowMap[b];
                    end else if (wasdMap.exists(b)) begin
                        e.cmd = wasdMap[b];
                    end
                end
                mExt = 1'b0;
                mBrk = 1'b0;
            end
        end
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic parityOk, input logic stopBit,
                                 input int firstBit, input int lastBit);
        logic        p;
        logic [10:0] bits;
        p    = parityOk ? ~^b : ^b;
        bits = {stopBit, p, b, 1'b0};
        for (int i = firstBit; i <= lastBit; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10 && firstBit == 0) modelFrame(b, p, stopBit, cyc + 3);
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (4 * HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic resetCounters();
        svPulses  = 0;
        cmdPulses = 0;
        errPulses = 0;
        lastCmd   = 3'b000;
    endtask

    task automatic compareLoop();
        exp_t       e;
        logic       expSv, expFe;
        logic [2:0] expCmd;
        forever begin
            @(negedge clk);
            expSv = 1'b0; expFe = 1'b0; expCmd = 3'b000;
            if (rstSampled) begin
                mCode = 8'h00;
            end else if (expQ.size() > 0 && expQ[0].at <= cyc) begin
                e = expQ.pop_front();
                if (e.at < cyc) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL stale_expectation: due cycle %0d, now %0d", e.at, cyc);
                end
                expSv  = e.sv;
                expFe  = e.fe;
                expCmd = e.cmd;
                if (e.sv) mCode = e.code;
            end
            if (scan_valid === 1'b1) svPulses++;
            if (frame_error === 1'b1) errPulses++;
            if (keyboard_signal !== 3'b000) begin
                cmdPulses++;
                lastCmd = keyboard_signal;
            end
            compared++;
            if (keyboard_signal !== expCmd || scan_valid !== expSv || scan_code !== mCode ||
                (!errWindow && frame_error !== expFe)) begin
                mismatched++;
                $display("[TB] FAIL cycle_%0d: got kb=%b sv=%b fe=%b code=%h, expected kb=%b sv=%b fe=%b code=%h",
                         cyc, keyboard_signal, scan_valid, frame_error, scan_code,
                         expCmd, expSv, expFe, mCode);
            end
        end
    endtask

    initial begin
        wasdMap[8'h1B]  = 3'b100; wasdMap[8'h1C]  = 3'b101;
        wasdMap[8'h23]  = 3'b110; wasdMap[8'h1D]  = 3'b111;
        arrowMap[8'h72] = 3'b100; arrowMap[8'h6B] = 3'b101;
        arrowMap[8'h74] = 3'b110; arrowMap[8'h75] = 3'b111;

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {19'd0, keyboard_signal, scan_code, scan_valid, frame_error}, 32'd0);
        rst = 1'b0;
        fork
            compareLoop();
        join_none

        // Extended down arrow
        resetCounters();
        applyStimulus(8'hE0, 1'b1, 1'b1, 0, 10);
        checkOutput("t1_no_cmd_after_e0", cmdPulses, 0);
        applyStimulus(8'h72, 1'b1, 1'b1, 0, 10);
        checkOutput("t1_sv_pulses", svPulses, 2);
        checkOutput("t1_cmd_pulses", cmdPulses, 1);
        checkOutput("t1_cmd_value", lastCmd, 3'b100);
        checkOutput("t1_scan_code", scan_code, 8'h72);

        // Left arrow break, then plain A
        resetCounters();
        applyStimulus(8'hE0, 1'b1, 1'b1, 0, 10);
        applyStimulus(8'hF0, 1'b1, 1'b1, 0, 10);
        applyStimulus(8'h6B, 1'b1, 1'b1, 0, 10);
        checkOutput("t2_no_cmd_on_break", cmdPulses, 0);
        applyStimulus(8'h1C, 1'b1, 1'b1, 0, 10);
        checkOutput("t2_sv_pulses", svPulses, 4);
        checkOutput("t2_cmd_pulses", cmdPulses, 1);
        checkOutput("t2_cmd_value", lastCmd, 3'b101);

        // Parity error then good W
        resetCounters();
        applyStimulus(8'h1D, 1'b0, 1'b1, 0, 10);
        checkOutput("t3_err_pulses", errPulses, 1);
        checkOutput("t3_no_sv", svPulses, 0);
        checkOutput("t3_code_kept", scan_code, 8'h1C);
        applyStimulus(8'h1D, 1'b1, 1'b1, 0, 10);
        checkOutput("t3_cmd_pulses", cmdPulses, 1);
        checkOutput("t3_cmd_value", lastCmd, 3'b111);

        // Timeout of a partial frame, then D
        resetCounters();
        errWindow = 1'b1;
        applyStimulus(8'h23, 1'b1, 1'b1, 0, 4);
        repeat (TIMEOUT + 40) @(negedge clk);
        errWindow = 1'b0;
        mExt = 1'b0; mBrk = 1'b0;
        checkOutput("t4_timeout_pulses", errPulses, 1);
        checkOutput("t4_no_sv", svPulses, 0);
        applyStimulus(8'h23, 1'b1, 1'b1, 0, 10);
        checkOutput("t4_cmd_pulses", cmdPulses, 1);
        checkOutput("t4_cmd_value", lastCmd, 3'b110);

        // Reset in mid-frame, leftover bits, then S
        applyStimulus(8'h1B, 1'b1, 1'b1, 0, 4);
        @(negedge clk);
        rst = 1'b1;
        mExt = 1'b0; mBrk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        errWindow = 1'b1;
        applyStimulus(8'h1B, 1'b1, 1'b1, 5, 10);
        repeat (TIMEOUT + 40) @(negedge clk);
        errWindow = 1'b0;
        mExt = 1'b0; mBrk = 1'b0;
        checkOutput("t5_code_cleared", scan_code, 8'h00);
        resetCounters();
        applyStimulus(8'h1B, 1'b1, 1'b1, 0, 10);
        checkOutput("t5_cmd_pulses", cmdPulses, 1);
        checkOutput("t5_cmd_value", lastCmd, 3'b100);

        // Unmapped keys, extended non-arrow, then plain A
        resetCounters();
        applyStimulus(8'h29, 1'b1, 1'b1, 0, 10);
        applyStimulus(8'hE0, 1'b1, 1'b1, 0, 10);
        applyStimulus(8'h1C, 1'b1, 1'b1, 0, 10);
        checkOutput("t6_no_cmd", cmdPulses, 0);
        checkOutput("t6_sv_pulses", svPulses, 3);
        applyStimulus(8'h1C, 1'b1, 1'b1, 0, 10);
        checkOutput("t6_cmd_pulses", cmdPulses, 1);
        checkOutput("t6_cmd_value", lastCmd, 3'b101);
        checkOutput("t6_queue_drained", expQ.size(), 0);

        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
